tick_uart_tx: RTL



---
 rtl/tick_uart_tx_if.sv | 26 ++
 rtl/tick_uart_tx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tick_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : tick_uart_tx_if
// Description : Word handshake between a producer and the tick-timed UART TX.
// Revision    : 1.0 - initial release
// ============================================================================
interface tick_uart_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/tick_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tick_uart_tx
// Description : Async-serial transmitter timed by an external divider strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_uart_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_TICKS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                tick_en,
    tick_uart_tx_if.slave       tx,
    output logic                tx_out,
    output logic                tx_busy,
    output logic                tx_done
);

    localparam int C_CNT_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int C_IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [C_CNT_W-1:0] C_TICK_LAST = C_CNT_W'(BIT_TICKS - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST  = C_IDX_W'(DATA_W - 1);
    localparam logic C_PAR_EN   = (PARITY_EN != 0);
    localparam logic C_PAR_ODD  = (PARITY_ODD != 0);
    localparam logic C_TWO_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t               r_state;
    logic [C_CNT_W-1:0]   r_tick_cnt;
    logic [DATA_W-1:0]    r_shift;
    logic [C_IDX_W-1:0]   r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_parity;
    logic                 r_tx_out;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;

    logic w_accept;
    logic w_bit_end;
    logic w_parity;

    assign w_accept  = tx.tx_valid & r_ready;
    assign w_bit_end = tick_en & (r_tick_cnt == C_TICK_LAST);
    assign w_parity  = (^tx.tx_data) ^ C_PAR_ODD;

    assign tx.tx_ready = r_ready;
    assign tx_out      = r_tx_out;
    assign tx_busy     = r_busy;
    assign tx_done     = r_done;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_parity   <= 1'b0;
            r_tx_out   <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift  <= tx.tx_data;
                        r_parity <= w_parity;
                        r_state  <= SYNC;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                // Waiting for a tick so the start bit begins on a tick boundary.
                SYNC: begin
                    if (tick_en) begin
                        r_state    <= START;
                        r_tx_out   <= 1'b0;
                        r_tick_cnt <= '0;
                    end
                end
                default: begin
                    if (tick_en && !w_bit_end) begin
                        r_tick_cnt <= r_tick_cnt + C_CNT_W'(1);
                    end else if (w_bit_end) begin
                        r_tick_cnt <= '0;
                        case (r_state)
                            START: begin
                                r_state   <= DATA;
                                r_tx_out  <= r_shift[0];
                                r_shift   <= r_shift >> 1;
                                r_bit_idx <= '0;
                            end
                            DATA: begin
                                if (r_bit_idx != C_IDX_LAST) begin
                                    r_tx_out  <= r_shift[0];
                                    r_shift   <= r_shift >> 1;
                                    r_bit_idx <= r_bit_idx + C_IDX_W'(1);
                                end else if (C_PAR_EN) begin
                                    r_state  <= PARITY;
                                    r_tx_out <= r_parity;
                                end else begin
                                    r_state    <= STOP;
                                    r_tx_out   <= 1'b1;
                                    r_stop_idx <= 1'b0;
                                end
                            end
                            PARITY: begin
                                r_state    <= STOP;
                                r_tx_out   <= 1'b1;
                                r_stop_idx <= 1'b0;
                            end
                            STOP: begin
                                if (r_stop_idx == C_TWO_STOP) begin
                                    r_state <= IDLE;
                                    r_done  <= 1'b1;
                                    r_ready <= 1'b1;
                                    r_busy  <= 1'b0;
                                end else begin
                                    r_stop_idx <= 1'b1;
                                end
                            end
                            default: begin
                                r_state  <= IDLE;
                                r_tx_out <= 1'b1;
                                r_ready  <= 1'b1;
                                r_busy   <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
